axi_err_responder: RTL and testbench

Terminating AXI4+ATOP responder: accepts every request on its slave port and answers with a fixed error response, fixed read data and correct burst framing. Placed behind the default/unmapped port of demuxes and crossbars, and behind `axi_isolate` so isolated subsystems still receive protocol-correct replies. Bounded outstanding tracking keeps the block small while never deadlocking the upstream master.

---
 rtl/axi_err_responder_pkg.sv | 75 +++++++
 rtl/axi_err_responder_fifo.sv | 58 +++++
 rtl/axi_err_responder.sv | 134 +++++++++++++
 tb/tb_axi_err_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/axi_err_responder_pkg.sv
// Shared types for the terminating AXI4+ATOP error responder: channel structs,
// response codes, ATOP bit positions and the read-side FSM encoding.
package axi_err_responder_pkg;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned USER_W = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // atop[5] set means the atomic also returns read data on R
   localparam int unsigned ATOP_R_RESP = 5;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic [5:0]        atop;
   } aw_chan_t;

   typedef struct packed {
      logic [DATA_W-1:0]   data;
      logic [DATA_W/8-1:0] strb;
      logic                last;
   } w_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } ar_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [1:0]        resp;
      logic [USER_W-1:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic              last;
      logic [USER_W-1:0] user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    ar_ready;
      logic    r_valid;
      r_chan_t r;
   } axi_resp_t;

   typedef enum logic {R_IDLE, R_SEND} r_state_e;
endpackage

// File: rtl/axi_err_responder_fifo.sv
// Small circular FIFO used for the W-pending, B and R bookkeeping queues.
// Callers gate push with full and pop with empty.
module axi_err_responder_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [DW-1:0]              data_i,
   input  logic                       pop_i,
   output logic [DW-1:0]              data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] usage_o
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
   logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]            cnt_q, cnt_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_i) begin
         mem_d[wptr_q] = data_i;
         wptr_d        = ptr_inc(wptr_q);
      end
      if (pop_i) rptr_d = ptr_inc(rptr_q);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data_o  = mem_q[rptr_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign usage_o = cnt_q;
endmodule

// File: rtl/axi_err_responder.sv
// Terminating AXI4+ATOP slave: accepts everything, answers every B and R beat
// with a fixed error code and fixed read data, keeping burst framing correct.
module axi_err_responder
   import axi_err_responder_pkg::*;
#(
   parameter int unsigned AxiIdWidth   = ID_W,
   parameter int unsigned AxiDataWidth = DATA_W,
   parameter type         req_t        = axi_req_t,
   parameter type         resp_t       = axi_resp_t,
   parameter logic [1:0]  Resp         = RESP_DECERR,
   parameter logic [31:0] RespData     = 32'hCA11_AB1E,
   parameter int unsigned MaxTrans     = 4
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  test_i,
   input  req_t  slv_req_i,
   output resp_t slv_resp_o
);
   localparam int unsigned CW = $clog2(MaxTrans+1);
   localparam int unsigned RW = AxiIdWidth + 8;

   logic                  rdy_q, rdy_d;
   r_state_e              state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;

   logic                  wp_full, wp_empty, b_full, b_empty, r_full, r_empty;
   logic [AxiIdWidth-1:0] wp_head, b_head;
   logic [RW-1:0]         r_head, r_in;
   logic [CW-1:0]         r_usage, unused_wp_usage, unused_b_usage;

   logic aw_atop_r, aw_ready, aw_hs, atop_push;
   logic ar_ready, ar_hs, r_push;
   logic w_ready, w_last_hs;
   logic b_valid, b_hs;
   logic r_valid, r_last, r_hs, r_last_hs, r_drain;

   // readies are held low for the first cycle out of reset
   assign aw_atop_r = slv_req_i.aw.atop[ATOP_R_RESP];
   assign aw_ready  = rdy_q & ~wp_full & (~aw_atop_r | ~r_full);
   assign aw_hs     = slv_req_i.aw_valid & aw_ready;
   assign atop_push = aw_hs & aw_atop_r;

   // an atomic needing read data owns the single R-queue push port this cycle
   assign ar_ready  = rdy_q & ~r_full & ~atop_push;
   assign ar_hs     = slv_req_i.ar_valid & ar_ready;
   assign r_push    = atop_push | ar_hs;
   assign r_in      = atop_push ? {slv_req_i.aw.id, slv_req_i.aw.len}
                                : {slv_req_i.ar.id, slv_req_i.ar.len};

   assign w_ready   = rdy_q & ~wp_empty & ~b_full;
   assign w_last_hs = slv_req_i.w_valid & w_ready & slv_req_i.w.last;

   assign b_valid   = ~b_empty;
   assign b_hs      = b_valid & slv_req_i.b_ready;

   assign r_valid   = ~r_empty;
   assign r_last    = r_valid & (cnt_q == r_head[7:0]);
   assign r_hs      = r_valid & slv_req_i.r_ready;
   assign r_last_hs = r_hs & r_last;
   assign r_drain   = r_last_hs & (r_usage == CW'(1)) & ~r_push;

   axi_err_responder_fifo #(.DW(AxiIdWidth), .DEPTH(MaxTrans)) i_wp_fifo (
      .clk_i, .rst_ni,
      .push_i (aw_hs),     .data_i (slv_req_i.aw.id),
      .pop_i  (w_last_hs), .data_o (wp_head),
      .full_o (wp_full),   .empty_o(wp_empty), .usage_o(unused_wp_usage)
   );

   axi_err_responder_fifo #(.DW(AxiIdWidth), .DEPTH(MaxTrans)) i_b_fifo (
      .clk_i, .rst_ni,
      .push_i (w_last_hs), .data_i (wp_head),
      .pop_i  (b_hs),      .data_o (b_head),
      .full_o (b_full),    .empty_o(b_empty), .usage_o(unused_b_usage)
   );

   axi_err_responder_fifo #(.DW(RW), .DEPTH(MaxTrans)) i_r_fifo (
      .clk_i, .rst_ni,
      .push_i (r_push),    .data_i (r_in),
      .pop_i  (r_last_hs), .data_o (r_head),
      .full_o (r_full),    .empty_o(r_empty), .usage_o(r_usage)
   );

   always_comb begin
      rdy_d   = 1'b1;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (r_hs) cnt_d = r_last ? 8'd0 : cnt_q + 8'd1;
      unique case (state_q)
         R_IDLE:  if (r_valid && !r_drain) state_d = R_SEND;
         R_SEND:  if (r_drain) state_d = R_IDLE;
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rdy_q   <= 1'b0;
         state_q <= R_IDLE;
         cnt_q   <= '0;
      end else begin
         rdy_q   <= rdy_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = aw_ready;
      slv_resp_o.w_ready  = w_ready;
      slv_resp_o.ar_ready = ar_ready;
      slv_resp_o.b_valid  = b_valid;
      slv_resp_o.r_valid  = r_valid;
      if (b_valid) begin
         slv_resp_o.b.id   = b_head;
         slv_resp_o.b.resp = Resp;
      end
      if (r_valid) begin
         slv_resp_o.r.id   = r_head[RW-1:8];
         slv_resp_o.r.data = {(AxiDataWidth/32){RespData}};
         slv_resp_o.r.resp = Resp;
         slv_resp_o.r.last = r_last;
      end
   end

   // write data and most address attributes are intentionally ignored
   logic unused_ok;
   assign unused_ok = ^{test_i, slv_req_i.w.data, slv_req_i.w.strb,
                        slv_req_i.aw.addr, slv_req_i.aw.size, slv_req_i.aw.burst,
                        slv_req_i.aw.atop[4:0], slv_req_i.ar.addr,
                        slv_req_i.ar.size, slv_req_i.ar.burst,
                        unused_wp_usage, unused_b_usage};
endmodule

// File: tb/tb_axi_err_responder.sv
// Randomized bench for axi_err_responder against a queue-based transaction model.
module tb_axi_err_responder;
   import axi_err_responder_pkg::*;

   localparam int MT = 4;
   localparam logic [63:0] RDATA = 64'hCA11AB1E_CA11AB1E;

   logic      clk = 1'b0;
   logic      rst_n = 1'b0;
   logic      test = 1'b0;
   axi_req_t  req;
   axi_resp_t rsp;

   always #5 clk = ~clk;

   axi_err_responder #(.MaxTrans(MT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .test_i(test),
      .slv_req_i(req), .slv_resp_o(rsp)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {int id; int len;} rtx_t;

   // model: outstanding transactions as plain queues
   int   wp_q[$];
   int   b_q[$];
   rtx_t r_q[$];
   int   rbeat = 0;
   bit   up = 0;
   // stimulus bookkeeping
   int   wlen_q[$];
   int   wbeat = 0;
   bit   aw_done, w_done, ar_done;

   initial begin
      int p_aw, p_w, p_b, p_ar, p_r, p_atop;
      bit e_aw_rdy, e_w_rdy, e_ar_rdy, e_b_vld, e_r_vld, e_r_last;
      bit aw_hs, w_hs, ar_hs, b_hs, r_hs, atop_r;
      req = '0;
      aw_done = 0; w_done = 0; ar_done = 0;
      for (int cyc = 0; cyc < 3600; cyc++) begin
         @(negedge clk);
         unique case ((cyc / 300) % 4)
            0: begin p_aw = 90; p_w = 100; p_b = 100; p_ar = 90; p_r = 100; p_atop = 10; end
            1: begin p_aw = 60; p_w = 80;  p_b = 5;   p_ar = 70; p_r = 5;   p_atop = 20; end
            2: begin p_aw = 50; p_w = 50;  p_b = 50;  p_ar = 50; p_r = 50;  p_atop = 30; end
            default: begin p_aw = 80; p_w = 90; p_b = 70; p_ar = 80; p_r = 70; p_atop = 70; end
         endcase
         rst_n = !(cyc < 2 || (cyc >= 1805 && cyc < 1808));
         if (!rst_n) begin
            req = '0;
            wlen_q.delete();
            wbeat = 0;
            aw_done = 0; w_done = 0; ar_done = 0;
         end else begin
            if (aw_done) req.aw_valid = 1'b0;
            if (w_done)  req.w_valid  = 1'b0;
            if (ar_done) req.ar_valid = 1'b0;
            if (!req.aw_valid && $urandom_range(99) < p_aw) begin
               req.aw_valid = 1'b1;
               req.aw.id    = 4'($urandom);
               req.aw.addr  = $urandom;
               req.aw.len   = 8'($urandom_range(3));
               req.aw.atop  = ($urandom_range(99) < p_atop) ? (6'b100000 | 6'($urandom_range(7))) : 6'b0;
            end
            if (!req.ar_valid && $urandom_range(99) < p_ar) begin
               req.ar_valid = 1'b1;
               req.ar.id    = 4'($urandom);
               req.ar.addr  = $urandom;
               req.ar.len   = 8'($urandom_range(7));
            end
            if (!req.w_valid && wlen_q.size() > 0 && $urandom_range(99) < p_w) begin
               req.w_valid = 1'b1;
               req.w.data  = {$urandom, $urandom};
               req.w.strb  = 8'hFF;
               req.w.last  = (wbeat == wlen_q[0]);
            end
            req.b_ready = ($urandom_range(99) < p_b);
            req.r_ready = ($urandom_range(99) < p_r);
         end
         aw_done = 0; w_done = 0; ar_done = 0;
         #1;
         atop_r   = req.aw.atop[5];
         e_aw_rdy = up && wp_q.size() < MT && (!atop_r || r_q.size() < MT);
         e_w_rdy  = up && wp_q.size() > 0 && b_q.size() < MT;
         e_ar_rdy = up && r_q.size() < MT && !(req.aw_valid && e_aw_rdy && atop_r);
         e_b_vld  = b_q.size() > 0;
         e_r_vld  = r_q.size() > 0;
         e_r_last = e_r_vld && (rbeat == r_q[0].len);
         check("aw_ready", 64'(rsp.aw_ready), 64'(e_aw_rdy));
         check("w_ready",  64'(rsp.w_ready),  64'(e_w_rdy));
         check("ar_ready", 64'(rsp.ar_ready), 64'(e_ar_rdy));
         check("b_valid",  64'(rsp.b_valid),  64'(e_b_vld));
         check("r_valid",  64'(rsp.r_valid),  64'(e_r_vld));
         if (!up) check("reset_zero", 64'(rsp == '0), 64'd1);
         if (e_b_vld) begin
            check("b_id",   64'(rsp.b.id),   64'(b_q[0]));
            check("b_resp", 64'(rsp.b.resp), 64'd3);
            check("b_user", 64'(rsp.b.user), 64'd0);
         end
         if (e_r_vld) begin
            check("r_id",   64'(rsp.r.id),   64'(r_q[0].id));
            check("r_data", rsp.r.data,      RDATA);
            check("r_resp", 64'(rsp.r.resp), 64'd3);
            check("r_last", 64'(rsp.r.last), 64'(e_r_last));
            check("r_user", 64'(rsp.r.user), 64'd0);
         end
         aw_hs = rst_n && req.aw_valid && e_aw_rdy;
         w_hs  = rst_n && req.w_valid && e_w_rdy;
         ar_hs = rst_n && req.ar_valid && e_ar_rdy;
         b_hs  = rst_n && e_b_vld && req.b_ready;
         r_hs  = rst_n && e_r_vld && req.r_ready;
         if (!rst_n) begin
            wp_q.delete(); b_q.delete(); r_q.delete();
            rbeat = 0;
            up = 0;
         end else begin
            up = 1;
            if (r_hs) begin
               if (e_r_last) begin void'(r_q.pop_front()); rbeat = 0; end
               else rbeat++;
            end
            if (b_hs) void'(b_q.pop_front());
            if (w_hs) begin
               w_done = 1;
               if (req.w.last) begin
                  b_q.push_back(wp_q.pop_front());
                  void'(wlen_q.pop_front());
                  wbeat = 0;
               end else wbeat++;
            end
            if (aw_hs) begin
               aw_done = 1;
               wp_q.push_back(int'(req.aw.id));
               wlen_q.push_back(int'(req.aw.len));
               if (atop_r) r_q.push_back('{int'(req.aw.id), int'(req.aw.len)});
            end
            if (ar_hs) begin
               ar_done = 1;
               r_q.push_back('{int'(req.ar.id), int'(req.ar.len)});
            end
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
